// File: rtl/serial_pad_poller.sv
// rtl/serial_pad_poller.sv - NES/SNES serial pad poller with frame-debounced button vectors
module serial_pad_poller #(
    parameter int NUM_PADS    = 2,
    parameter int NUM_BITS    = 8,
    parameter int HALF_PERIOD = 6,
    parameter int POLL_GAP    = 100,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic [NUM_PADS-1:0]          data_in,
    output logic                         latch_out,
    output logic                         clk_out,
    output logic [NUM_PADS*NUM_BITS-1:0] buttons,
    output logic [NUM_PADS*NUM_BITS-1:0] pressed,
    output logic [NUM_PADS*NUM_BITS-1:0] released,
    output logic                         frame_valid,
    output logic                         busy
);

    localparam int W     = NUM_PADS * NUM_BITS;
    localparam int CNT_W = $clog2(2 * HALF_PERIOD);
    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int IDX_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

    localparam logic [CNT_W-1:0]    LATCH_LAST = CNT_W'(2 * HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0]    HALF_LAST  = CNT_W'(HALF_PERIOD - 1);
    localparam logic [GAP_W-1:0]    GAP_LAST   = GAP_W'(POLL_GAP - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(NUM_BITS - 1);
    localparam logic [NUM_PADS-1:0] POLARITY   = {NUM_PADS{ACTIVE_LOW}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [GAP_W-1:0]   gap;
    logic [IDX_W-1:0]   idx;
    logic [W-1:0]       frame_word;
    logic [NUM_PADS-1:0] sample;
    logic               sample_now;

    // Stored polarity is always 1 = pressed, whatever the pad wiring.
    assign sample     = data_in ^ POLARITY;
    assign sample_now = (state == S_LOW) && (cnt == HALF_LAST);

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        logic [NUM_BITS-1:0] shift_reg;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                shift_reg <= '0;
            end else if (sample_now) begin
                shift_reg[idx] <= sample[p];
            end
        end

        assign frame_word[p*NUM_BITS +: NUM_BITS] = shift_reg;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            gap         <= '0;
            idx         <= '0;
            latch_out   <= 1'b0;
            clk_out     <= 1'b0;
            busy        <= 1'b0;
            buttons     <= '0;
            pressed     <= '0;
            released    <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            pressed     <= '0;
            released    <= '0;
            case (state)
                S_IDLE: begin
                    if (gap == GAP_LAST) begin
                        if (enable) begin
                            state     <= S_LATCH;
                            cnt       <= '0;
                            latch_out <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end else begin
                        gap <= gap + GAP_W'(1);
                    end
                end
                S_LATCH: begin
                    if (cnt == LATCH_LAST) begin
                        state     <= S_LOW;
                        cnt       <= '0;
                        idx       <= '0;
                        latch_out <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_LOW: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (idx == IDX_LAST) begin
                            state <= S_DONE;
                        end else begin
                            state   <= S_HIGH;
                            clk_out <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_HIGH: begin
                    if (cnt == HALF_LAST) begin
                        state   <= S_LOW;
                        cnt     <= '0;
                        idx     <= idx + IDX_W'(1);
                        clk_out <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    // Publish the whole frame at once so consumers never see a partial read.
                    buttons     <= frame_word;
                    pressed     <= frame_word & ~buttons;
                    released    <= ~frame_word & buttons;
                    frame_valid <= 1'b1;
                    busy        <= 1'b0;
                    gap         <= '0;
                    state       <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pad_poller.sv
// tb/tb_serial_pad_poller.sv - randomized bench for serial_pad_poller against an edge-schedule model
module tb_serial_pad_poller;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n_a, reset_n_b, enable_a, enable_b;
    logic [1:0]  data_a;
    logic [0:0]  data_b;
    logic        latch_a, clk_a, fv_a, busy_a;
    logic        latch_b, clk_b, fv_b, busy_b;
    logic [15:0] buttons_a, pressed_a, released_a;
    logic [15:0] buttons_b, pressed_b, released_b;

    serial_pad_poller #(
        .NUM_PADS(2), .NUM_BITS(8), .HALF_PERIOD(2), .POLL_GAP(4), .ACTIVE_LOW(1'b1)
    ) dut_a (
        .clock(clock), .reset_n(reset_n_a), .enable(enable_a), .data_in(data_a),
        .latch_out(latch_a), .clk_out(clk_a), .buttons(buttons_a), .pressed(pressed_a),
        .released(released_a), .frame_valid(fv_a), .busy(busy_a)
    );

    serial_pad_poller #(
        .NUM_PADS(1), .NUM_BITS(16), .HALF_PERIOD(1), .POLL_GAP(3), .ACTIVE_LOW(1'b0)
    ) dut_b (
        .clock(clock), .reset_n(reset_n_b), .enable(enable_b), .data_in(data_b),
        .latch_out(latch_b), .clk_out(clk_b), .buttons(buttons_b), .pressed(pressed_b),
        .released(released_b), .frame_valid(fv_b), .busy(busy_b)
    );

    function automatic int hp(input int d);  return (d == 0) ? 2 : 1;  endfunction
    function automatic int nb(input int d);  return (d == 0) ? 8 : 16; endfunction
    function automatic int np(input int d);  return (d == 0) ? 2 : 1;  endfunction
    function automatic int gp(input int d);  return (d == 0) ? 4 : 3;  endfunction
    function automatic int al(input int d);  return (d == 0) ? 1 : 0;  endfunction
    function automatic int fl(input int d);
        return 2 * hp(d) + nb(d) * hp(d) + (nb(d) - 1) * hp(d) + 1;
    endfunction

    int tests, fails;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic        o_latch, o_clk, o_busy, o_fv;
    logic [15:0] o_btn, o_prs, o_rel;

    // Reference state: edge numbers since reset release, frame start edge, idle start edge.
    int          cyc, m_start, m_idle, m_frames, lat_edge, pulses;
    logic [15:0] m_cap, m_btn, m_prs, m_rel, pad_btn;
    logic        m_fv, prev_latch, prev_clk;

    task automatic observe(input int d);
        if (d == 0) begin
            o_latch = latch_a; o_clk = clk_a; o_busy = busy_a; o_fv = fv_a;
            o_btn = buttons_a; o_prs = pressed_a; o_rel = released_a;
        end else begin
            o_latch = latch_b; o_clk = clk_b; o_busy = busy_b; o_fv = fv_b;
            o_btn = buttons_b; o_prs = pressed_b; o_rel = released_b;
        end
    endtask

    task automatic step(input int d, input bit en);
        int e, k, j, bit_i;
        logic [1:0] line;
        logic el, ec, eb;
        e    = cyc + 1;
        line = 2'($urandom);
        // Data line is noise except in the cycle right before a sampling edge.
        if (m_start >= 0) begin
            k = e - m_start - 3 * hp(d);
            if (k >= 0 && (k % (2 * hp(d))) == 0 && (k / (2 * hp(d))) < nb(d)) begin
                bit_i = k / (2 * hp(d));
                for (int p = 0; p < np(d); p++) begin
                    m_cap[p*nb(d)+bit_i] = pad_btn[p*nb(d)+bit_i];
                    line[p] = pad_btn[p*nb(d)+bit_i] ^ (al(d) == 1);
                end
            end
        end
        if (d == 0) begin data_a = line; enable_a = en; end
        else begin data_b = line[0]; enable_b = en; end
        @(negedge clock);
        m_fv = 1'b0;
        if (m_start < 0) begin
            if ((e - m_idle) >= gp(d) && en) m_start = e;
        end else if ((e - m_start) == fl(d)) begin
            m_prs = m_cap & ~m_btn;
            m_rel = ~m_cap & m_btn;
            m_btn = m_cap;
            m_fv = 1'b1;
            m_start = -1;
            m_idle = e;
            m_frames++;
        end
        cyc = e;
        el = 1'b0; ec = 1'b0; eb = 1'b0;
        if (m_start >= 0) begin
            k  = e - m_start;
            j  = k - 2 * hp(d);
            el = (k < 2 * hp(d));
            ec = (j >= 0) && (j < (2 * nb(d) - 1) * hp(d)) && ((j % (2 * hp(d))) >= hp(d));
            eb = 1'b1;
        end
        observe(d);
        check("ctl", {o_latch, o_clk, o_busy, o_fv}, {el, ec, eb, m_fv});
        check("buttons", o_btn, m_btn);
        check("events", {o_prs, o_rel}, m_fv ? {m_prs, m_rel} : 32'h0);
        if (o_latch && !prev_latch) begin lat_edge = cyc; pulses = 0; end
        if (o_clk && !prev_clk) pulses++;
        if (o_fv) begin
            check("pulse_count", pulses, nb(d) - 1);
            check("frame_len", cyc - lat_edge, fl(d));
        end
        prev_latch = o_latch;
        prev_clk   = o_clk;
    endtask

    task automatic do_reset(input int d);
        if (d == 0) reset_n_a = 1'b0; else reset_n_b = 1'b0;
        #1;
        observe(d);
        check("reset_zero", {o_latch, o_clk, o_busy, o_fv, o_btn, o_prs, o_rel}, 64'h0);
        repeat (2) @(negedge clock);
        if (d == 0) reset_n_a = 1'b1; else reset_n_b = 1'b1;
        cyc = 0; m_start = -1; m_idle = 0;
        m_cap = '0; m_btn = '0; m_prs = '0; m_rel = '0; m_fv = 1'b0;
        prev_latch = 1'b0; prev_clk = 1'b0; pulses = 0; lat_edge = 0;
    endtask

    // en_mode: 0 = enable high, 1 = random while idle, 2 = enable low
    task automatic run_frames(input int d, input int n, input int en_mode);
        int target, budget;
        bit en;
        target = m_frames + n;
        budget = 3000;
        while (m_frames < target && budget > 0) begin
            if (en_mode == 0) en = 1'b1;
            else if (en_mode == 2) en = 1'b0;
            else en = (m_start >= 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            step(d, en);
            budget--;
        end
        if (m_frames < target) check("frame_timeout", m_frames, target);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int budget;
        tests = 0; fails = 0; m_frames = 0;
        reset_n_a = 1'b0; reset_n_b = 1'b0; enable_a = 1'b0; enable_b = 1'b0;
        data_a = '0; data_b = '0; pad_btn = '0;
        @(negedge clock);

        do_reset(0);
        pad_btn = 16'h0081;
        run_frames(0, 1, 0);
        check("f1_buttons", o_btn, 16'h0081);
        check("f1_pressed", o_prs, 16'h0081);
        check("f1_released", o_rel, 16'h0000);
        pad_btn = 16'h0088;
        run_frames(0, 1, 0);
        check("f2_buttons", o_btn, 16'h0088);
        check("f2_pressed", o_prs, 16'h0008);
        check("f2_released", o_rel, 16'h0001);
        step(0, 1'b1);
        check("f2_events_clear", {o_prs, o_rel}, 32'h0);
        check("f2_buttons_hold", o_btn, 16'h0088);
        repeat (6) begin
            pad_btn = 16'($urandom);
            run_frames(0, 1, 1);
        end

        do_reset(0);
        repeat (20) step(0, 1'b0);
        check("en_low_idle", {o_latch, o_busy}, 2'b00);
        pad_btn = 16'($urandom);
        step(0, 1'b1);
        check("en_rise_latch", o_latch, 1'b1);
        run_frames(0, 1, 2);
        check("en_drop_completes", o_fv, 1'b1);
        repeat (40) step(0, 1'b0);

        pad_btn = 16'($urandom);
        budget = 300;
        while (!(m_start >= 0 && (cyc - m_start) == 21) && budget > 0) begin
            step(0, 1'b1);
            budget--;
        end
        if (!(m_start >= 0 && (cyc - m_start) == 21)) check("reach_bit4", cyc - m_start, 21);
        do_reset(0);
        repeat (2) begin
            pad_btn = 16'($urandom);
            run_frames(0, 1, 0);
        end

        reset_n_a = 1'b0;
        do_reset(1);
        pad_btn = 16'hA5C3;
        run_frames(1, 1, 0);
        check("snes_buttons", o_btn, 16'hA5C3);
        repeat (4) begin
            pad_btn = 16'($urandom);
            run_frames(1, 1, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
